d_pattern_player: RTL and testbench

Synthesizable serial stimulus source that plays a loaded bit pattern onto a single-bit `D` line, one bit per `Clock` cycle. It is the hardware driving end of the `D`/`Clock` interface that feeds the latch/flip-flop comparison block. It replaces hand-timed `D` waveforms with a repeatable, cycle-exact sequence. It sits upstream of the storage-element block and shares its `Clock`.

---
 rtl/d_pattern_player.sv | 118 +++++++++++
 tb/tb_d_pattern_player.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/d_pattern_player.sv
// Serial stimulus source: plays a loaded bit pattern onto D, bit 0 first,
// one bit per clock, optionally looping until Stop.
module d_pattern_player #(
    parameter int WIDTH = 16,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [LW-1:0]    Length,
    input  logic             Repeat,
    input  logic             Start,
    input  logic             Stop,
    output logic             D,
    output logic             Busy,
    output logic             Loaded,
    output logic             Done,
    output logic [LW-1:0]    BitIndex
);

    typedef enum logic [1:0] {IDLE, LOADED, PLAY} state_t;

    localparam logic [LW-1:0] MAX_LEN = LW'(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] pattern_reg, pattern_next;
    logic [LW-1:0]    len_reg, len_next;
    logic [LW-1:0]    index_reg, index_next;
    logic             repeat_reg, repeat_next;
    logic             d_reg, d_next;
    logic             done_reg, done_next;

    logic [LW-1:0]    clamped_len;
    logic [LW-1:0]    index_inc;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             load_ok;

    assign clamped_len = (Length > MAX_LEN) ? MAX_LEN : Length;
    assign index_inc   = index_reg + LW'(1);
    assign shifted     = pattern_reg >> index_inc;
    assign last_bit    = (index_reg == (len_reg - LW'(1)));
    assign load_ok     = Load && (Length != '0);

    always_comb begin
        state_next   = state;
        pattern_next = pattern_reg;
        len_next     = len_reg;
        repeat_next  = repeat_reg;
        index_next   = '0;
        d_next       = 1'b0;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    state_next   = LOADED;
                    pattern_next = Pattern;
                    len_next     = clamped_len;
                end
            end
            LOADED: begin
                // Start has priority over a simultaneous Load.
                if (Start) begin
                    state_next  = PLAY;
                    repeat_next = Repeat;
                    d_next      = pattern_reg[0];
                end else if (load_ok) begin
                    pattern_next = Pattern;
                    len_next     = clamped_len;
                end
            end
            PLAY: begin
                if (Stop) begin
                    state_next = LOADED;
                end else if (last_bit) begin
                    if (repeat_reg) begin
                        d_next = pattern_reg[0];
                    end else begin
                        state_next = LOADED;
                        done_next  = 1'b1;
                    end
                end else begin
                    index_next = index_inc;
                    d_next     = shifted[0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            pattern_reg <= '0;
            len_reg     <= '0;
            index_reg   <= '0;
            repeat_reg  <= 1'b0;
            d_reg       <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state       <= state_next;
            pattern_reg <= pattern_next;
            len_reg     <= len_next;
            index_reg   <= index_next;
            repeat_reg  <= repeat_next;
            d_reg       <= d_next;
            done_reg    <= done_next;
        end
    end

    assign D        = d_reg;
    assign Busy     = (state == PLAY);
    assign Loaded   = (state != IDLE);
    assign Done     = done_reg;
    assign BitIndex = index_reg;

endmodule

// File: tb/tb_d_pattern_player.sv
// Randomized and directed bench for d_pattern_player, checked against a
// model that derives the output from elapsed cycles since Start.
module tb_d_pattern_player;

    localparam int WIDTH = 16;
    localparam int LW    = $clog2(WIDTH + 1);

    logic             Clock = 1'b0;
    logic             Reset, Load, Repeat, Start, Stop;
    logic [WIDTH-1:0] Pattern;
    logic [LW-1:0]    Length;
    logic             D, Busy, Loaded, Done;
    logic [LW-1:0]    BitIndex;

    int checkCount = 0;
    int errorCount = 0;
    int cyc = 0;

    bit               m_has, m_play, m_rpt, m_done;
    logic [WIDTH-1:0] m_pat;
    int               m_len, m_start;

    d_pattern_player #(.WIDTH(WIDTH), .LW(LW)) dut (
        .Clock(Clock), .Reset(Reset), .Load(Load), .Pattern(Pattern),
        .Length(Length), .Repeat(Repeat), .Start(Start), .Stop(Stop),
        .D(D), .Busy(Busy), .Loaded(Loaded), .Done(Done), .BitIndex(BitIndex)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     tag, cyc, observed, expected);
        end
    endtask

    // Model works from "how many cycles since Start": bit = pattern[elapsed % len].
    task automatic updateModel(input bit rst, input bit ld, input logic [WIDTH-1:0] pat,
                               input int len, input bit rpt, input bit st, input bit sp);
        cyc++;
        m_done = 0;
        if (rst) begin
            m_has = 0; m_play = 0; m_pat = '0; m_len = 0;
        end else if (m_play) begin
            if (sp) m_play = 0;
            else if (!m_rpt && (cyc - m_start) == m_len) begin
                m_play = 0;
                m_done = 1;
            end
        end else if (m_has && st) begin
            m_play = 1; m_start = cyc; m_rpt = rpt;
        end else if (ld && len != 0) begin
            m_has = 1; m_pat = pat; m_len = (len > WIDTH) ? WIDTH : len;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit ld, input logic [WIDTH-1:0] pat,
                                 input int len, input bit rpt, input bit st, input bit sp);
        int idx;
        bit expD;
        Reset = rst; Load = ld; Pattern = pat; Length = LW'(len);
        Repeat = rpt; Start = st; Stop = sp;
        @(posedge Clock);
        updateModel(rst, ld, pat, len, rpt, st, sp);
        #1;
        idx  = m_play ? (cyc - m_start) % m_len : 0;
        expD = m_play ? m_pat[idx] : 1'b0;
        checkOutput("D", 64'(D), 64'(expD));
        checkOutput("Busy", 64'(Busy), 64'(m_play));
        checkOutput("Loaded", 64'(Loaded), 64'(m_has));
        checkOutput("Done", 64'(Done), 64'(m_done));
        checkOutput("BitIndex", 64'(BitIndex), 64'(idx));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0, 0);
    endtask

    initial begin
        m_has = 0; m_play = 0; m_rpt = 0; m_done = 0; m_pat = '0; m_len = 0; m_start = 0;
        applyStimulus(1, 0, '0, 0, 0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0, 0, 0);

        $display("[TB] 8-bit single play");
        applyStimulus(0, 1, 16'h00B5, 8, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        idx_dummy: idle(10);

        $display("[TB] 3-bit repeat then stop");
        applyStimulus(0, 1, 16'h0005, 3, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 1, 0);
        idle(8);
        applyStimulus(0, 0, '0, 0, 0, 0, 1);
        idle(3);

        $display("[TB] zero length and clamping");
        applyStimulus(1, 0, '0, 0, 0, 0, 0);
        applyStimulus(0, 1, 16'hFFFF, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        applyStimulus(0, 1, 16'hA5C3, 20, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        idle(18);

        $display("[TB] load ignored in play, start beats load");
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        applyStimulus(0, 1, 16'h1234, 5, 0, 0, 0);
        applyStimulus(0, 1, 16'h0F0F, 4, 0, 1, 0);
        idle(18);
        applyStimulus(0, 1, 16'h0F0F, 4, 0, 1, 0);
        idle(20);

        $display("[TB] stop on last bit, restart");
        applyStimulus(0, 1, 16'h000B, 4, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        idle(3);
        applyStimulus(0, 0, '0, 0, 0, 0, 1);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        idle(6);

        $display("[TB] length 1 single and repeat");
        applyStimulus(0, 1, 16'h0001, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        idle(3);
        applyStimulus(0, 0, '0, 0, 1, 1, 0);
        idle(4);
        applyStimulus(0, 0, '0, 0, 0, 0, 1);

        $display("[TB] reset mid-play");
        applyStimulus(0, 1, 16'h00FF, 8, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        idle(3);
        applyStimulus(1, 0, '0, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1, 0);
        idle(3);

        $display("[TB] random phase");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 5) == 0),
                          WIDTH'($urandom),
                          int'($urandom_range(0, 22)),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
